// File: rtl/tcam_search_if.sv
// Request/response bundle for tcam_search: write, invalidate, flush, search and result stream.
// master = requester side, slave = the TCAM.
interface tcam_search_if #(
  parameter int CAM_DW = 32,
  parameter int CAM_AW = 4
) ();
  logic              wr_valid;
  logic [CAM_AW-1:0] wr_addr;
  logic [CAM_DW-1:0] wr_data;
  logic [CAM_DW-1:0] wr_care;
  logic              wr_ready;

  logic              inv_valid;
  logic [CAM_AW-1:0] inv_addr;
  logic              inv_ready;

  logic              flush;

  logic              srch_valid;
  logic [CAM_DW-1:0] srch_key;
  logic [CAM_DW-1:0] srch_mask;
  logic              srch_ready;

  logic              res_valid;
  logic              res_ready;
  logic              res_hit;
  logic [CAM_AW-1:0] res_addr;
  logic [CAM_DW-1:0] res_data;
  logic              res_last;
  logic [CAM_AW:0]   match_cnt;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_care,
    output inv_valid, inv_addr,
    output flush,
    output srch_valid, srch_key, srch_mask,
    output res_ready,
    input  wr_ready, inv_ready, srch_ready,
    input  res_valid, res_hit, res_addr, res_data, res_last, match_cnt
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_care,
    input  inv_valid, inv_addr,
    input  flush,
    input  srch_valid, srch_key, srch_mask,
    input  res_ready,
    output wr_ready, inv_ready, srch_ready,
    output res_valid, res_hit, res_addr, res_data, res_last, match_cnt
  );
endinterface

// File: rtl/tcam_search.sv
// Ternary CAM with per-entry care bits and per-search mask; streams every hit
// in ascending address order, or a single miss beat when nothing matches.
module tcam_search #(
  parameter int CAM_DW = 32,
  parameter int CAM_AW = 4
) (
  input logic          clk,
  input logic          rst,
  tcam_search_if.slave bus
);
  localparam int unsigned DEPTH = 1 << CAM_AW;

  typedef enum logic [1:0] {IDLE, MATCH, DRAIN} state_t;

  state_t            state;
  logic [CAM_DW-1:0] data_mem [DEPTH];
  logic [CAM_DW-1:0] care_mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  hit_vec;
  logic [DEPTH-1:0]  match_vec;
  logic [DEPTH-1:0]  sel_vec;
  logic [CAM_DW-1:0] key_q;
  logic [CAM_DW-1:0] mask_q;
  logic [CAM_AW-1:0] sel_idx;
  logic              sel_found;
  logic [CAM_AW:0]   sel_cnt;
  logic              wr_fire;
  logic              inv_fire;
  logic              srch_fire;
  logic              res_fire;

  assign bus.wr_ready   = (state == IDLE);
  assign bus.inv_ready  = (state == IDLE) && !bus.wr_valid;
  assign bus.srch_ready = (state == IDLE) && !bus.wr_valid && !bus.inv_valid && !bus.flush;

  assign wr_fire   = bus.wr_valid && bus.wr_ready;
  assign inv_fire  = bus.inv_valid && bus.inv_ready;
  assign srch_fire = bus.srch_valid && bus.srch_ready;
  assign res_fire  = bus.res_valid && bus.res_ready;

  always_comb begin
    match_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid[i] && (((data_mem[i] ^ key_q) & care_mem[i] & mask_q) == '0);
    end
  end

  // sel_vec is the set the next beat is chosen from: the fresh match set in
  // MATCH, or the pending set minus the beat being handed off in DRAIN.
  always_comb begin
    sel_vec = '0;
    if (state == MATCH) begin
      sel_vec = match_vec;
    end else begin
      sel_vec = hit_vec;
      sel_vec[bus.res_addr] = 1'b0;
    end
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_cnt   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel_vec[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = CAM_AW'(i);
      end
      sel_cnt = sel_cnt + (CAM_AW + 1)'(sel_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      data_mem[bus.wr_addr] <= bus.wr_data;
      care_mem[bus.wr_addr] <= bus.wr_care;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      hit_vec       <= '0;
      key_q         <= '0;
      mask_q        <= '0;
      bus.res_valid <= 1'b0;
      bus.res_hit   <= 1'b0;
      bus.res_addr  <= '0;
      bus.res_data  <= '0;
      bus.res_last  <= 1'b0;
      bus.match_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Later assignments win, so a same-cycle write survives a flush.
          if (bus.flush) valid <= '0;
          if (inv_fire) valid[bus.inv_addr] <= 1'b0;
          if (wr_fire) valid[bus.wr_addr] <= 1'b1;
          if (srch_fire) begin
            key_q  <= bus.srch_key;
            mask_q <= bus.srch_mask;
            state  <= MATCH;
          end
        end
        MATCH: begin
          hit_vec       <= sel_vec;
          bus.match_cnt <= sel_cnt;
          bus.res_valid <= 1'b1;
          bus.res_hit   <= sel_found;
          bus.res_addr  <= sel_idx;
          bus.res_data  <= sel_found ? data_mem[sel_idx] : '0;
          bus.res_last  <= (sel_cnt <= (CAM_AW + 1)'(1));
          state         <= DRAIN;
        end
        DRAIN: begin
          if (res_fire) begin
            if (bus.res_last) begin
              bus.res_valid <= 1'b0;
              state         <= IDLE;
            end else begin
              hit_vec      <= sel_vec;
              bus.res_hit  <= 1'b1;
              bus.res_addr <= sel_idx;
              bus.res_data <= data_mem[sel_idx];
              bus.res_last <= (sel_cnt == (CAM_AW + 1)'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tcam_search.sv
// Self-checking bench for tcam_search: directed scenarios plus randomized
// traffic scored against an array-based model of the table.
module tb_tcam_search;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int BW    = 2 + AW + DW + 1 + (AW + 1) + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  bit [DW-1:0] m_data  [DEPTH];
  bit [DW-1:0] m_care  [DEPTH];
  bit          m_valid [DEPTH];

  tcam_search_if #(.CAM_DW(DW), .CAM_AW(AW)) bus ();

  tcam_search #(.CAM_DW(DW), .CAM_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] observe();
    return {bus.res_valid, bus.res_hit, bus.res_addr, bus.res_data, bus.res_last,
            bus.match_cnt, bus.wr_ready, bus.inv_ready, bus.srch_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int addr, input logic [DW-1:0] data, input logic [DW-1:0] care);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(addr);
    bus.wr_data  = data;
    bus.wr_care  = care;
    tick();
    bus.wr_valid = 1'b0;
    m_data[addr]  = data;
    m_care[addr]  = care;
    m_valid[addr] = 1'b1;
  endtask

  task automatic do_inv(input int addr);
    bus.inv_valid = 1'b1;
    bus.inv_addr  = AW'(addr);
    tick();
    bus.inv_valid = 1'b0;
    m_valid[addr] = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  // Issues one search and drains it, checking every beat against the model.
  task automatic run_search(input string name, input logic [DW-1:0] key,
                            input logic [DW-1:0] mask, input bit stall);
    int hits[$];
    int n_beats;
    int stalls;
    logic [BW-1:0] act;
    logic [BW-1:0] exp;
    hits = {};
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && ((m_data[i] & m_care[i] & mask) == (key & m_care[i] & mask)))
        hits.push_back(i);
    bus.srch_key   = key;
    bus.srch_mask  = mask;
    bus.srch_valid = 1'b1;
    #1;
    if (bus.srch_ready !== 1'b1)
      $display("FAIL %s srch_ready: got %b expected 1", name, bus.srch_ready);
    else n_pass++;
    n_total++;
    tick();
    bus.srch_valid = 1'b0;
    if (bus.res_valid !== 1'b0)
      $display("FAIL %s early res_valid: got %b expected 0", name, bus.res_valid);
    else n_pass++;
    n_total++;
    tick();
    n_beats = (hits.size() == 0) ? 1 : hits.size();
    for (int b = 0; b < n_beats; b++) begin
      if (hits.size() == 0)
        exp = {1'b1, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1, {(AW + 1){1'b0}}, 3'b000};
      else
        exp = {1'b1, 1'b1, AW'(hits[b]), m_data[hits[b]], (b == n_beats - 1),
               (AW + 1)'(hits.size()), 3'b000};
      stalls = stall ? $urandom_range(1, 2) : 0;
      for (int s = 0; s <= stalls; s++) begin
        bus.res_ready = (s == stalls);
        #1;
        act = observe();
        if (act !== exp)
          $display("FAIL %s beat %0d cyc %0d: got %h expected %h", name, b, s, act, exp);
        else n_pass++;
        n_total++;
        tick();
      end
    end
    bus.res_ready = 1'b0;
    #1;
    if ({bus.res_valid, bus.srch_ready} !== 2'b01)
      $display("FAIL %s return to idle: got %b expected 01", name, {bus.res_valid, bus.srch_ready});
    else n_pass++;
    n_total++;
  endtask

  task automatic test_reset();
    logic [BW-1:0] exp;
    rst = 1'b1;
    tick();
    tick();
    exp = {{(BW - 3){1'b0}}, 3'b111};
    if (observe() !== exp)
      $display("FAIL reset outputs: got %h expected %h", observe(), exp);
    else n_pass++;
    n_total++;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic test_empty();
    run_search("empty_ones", '1, '1, 1'b0);
    run_search("empty_mask0", 32'h1234_5678, '0, 1'b1);
  endtask

  task automatic test_single();
    do_write(2, 32'h0000_00A5, 32'hFFFF_FFFF);
    run_search("single", 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_stall_order();
    do_write(1, 32'h4000_0000, 32'hE000_0000);
    do_write(5, 32'h4000_0000, 32'hE000_0000);
    do_write(9, 32'h4000_0000, 32'hE000_0000);
    run_search("order", 32'h5FFF_FFFF, 32'hE000_0000, 1'b1);
  endtask

  task automatic test_inv_flush();
    do_inv(5);
    run_search("after_inv", 32'h5FFF_FFFF, 32'hE000_0000, 1'b1);
    do_flush();
    run_search("after_flush", 32'h5FFF_FFFF, 32'hE000_0000, 1'b0);
    do_write(6, 32'hCAFE_0006, '1);
    bus.flush    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(3);
    bus.wr_data  = 32'hBEEF_0003;
    bus.wr_care  = '1;
    tick();
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_data[3]  = 32'hBEEF_0003;
    m_care[3]  = '1;
    m_valid[3] = 1'b1;
    run_search("flush_write", '0, '0, 1'b0);
  endtask

  task automatic test_concurrent();
    bus.wr_valid   = 1'b1;
    bus.wr_addr    = AW'(7);
    bus.wr_data    = 32'h1234_5678;
    bus.wr_care    = '1;
    bus.inv_valid  = 1'b1;
    bus.inv_addr   = AW'(3);
    bus.srch_valid = 1'b1;
    bus.srch_key   = 32'h1234_5678;
    bus.srch_mask  = '1;
    #1;
    if ({bus.wr_ready, bus.inv_ready, bus.srch_ready} !== 3'b100)
      $display("FAIL concurrent readies: got %b expected 100",
               {bus.wr_ready, bus.inv_ready, bus.srch_ready});
    else n_pass++;
    n_total++;
    tick();
    bus.wr_valid   = 1'b0;
    bus.inv_valid  = 1'b0;
    bus.srch_valid = 1'b0;
    m_data[7]  = 32'h1234_5678;
    m_care[7]  = '1;
    m_valid[7] = 1'b1;
    #1;
    if ({bus.res_valid, bus.srch_ready} !== 2'b01)
      $display("FAIL concurrent search refused: got %b expected 01", {bus.res_valid, bus.srch_ready});
    else n_pass++;
    n_total++;
    run_search("concurrent", 32'h1234_5678, '1, 1'b0);
    run_search("inv_refused", 32'hBEEF_0003, '1, 1'b0);
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) do_write(i, $urandom, $urandom);
    run_search("full", $urandom, '0, 1'b1);
  endtask

  task automatic test_reset_mid_drain();
    logic [BW-1:0] exp;
    bus.srch_key   = '0;
    bus.srch_mask  = '0;
    bus.srch_valid = 1'b1;
    tick();
    bus.srch_valid = 1'b0;
    tick();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    rst = 1'b1;
    tick();
    exp = {{(BW - 3){1'b0}}, 3'b111};
    if (observe() !== exp)
      $display("FAIL reset mid-drain: got %h expected %h", observe(), exp);
    else n_pass++;
    n_total++;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    run_search("post_reset", '0, '0, 1'b0);
  endtask

  task automatic test_random();
    int op;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      if (op < 5)
        do_write($urandom_range(0, DEPTH - 1), $urandom & 32'hF, $urandom | 32'hFFFF_FFF0);
      else if (op < 7)
        do_inv($urandom_range(0, DEPTH - 1));
      else if (op == 7 && ($urandom_range(0, 3) == 0))
        do_flush();
      else
        run_search("random", $urandom & 32'hF, $urandom, $urandom_range(0, 1));
    end
    run_search("random_final", $urandom & 32'hF, $urandom, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_valid   = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.wr_care    = '0;
    bus.inv_valid  = 1'b0;
    bus.inv_addr   = '0;
    bus.flush      = 1'b0;
    bus.srch_valid = 1'b0;
    bus.srch_key   = '0;
    bus.srch_mask  = '0;
    bus.res_ready  = 1'b0;
    test_reset();
    test_empty();
    test_single();
    test_stall_order();
    test_inv_flush();
    test_concurrent();
    test_full();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tcam_search.md
TCAM_SEARCH -- requirements
Module: tcam_search

Interface
REQ-001 SHALL have parameter CAM_DW, default 32, meaning stored/search key width in bits.
REQ-002 SHALL have parameter CAM_AW, default 4, meaning entry address width; depth = 2**CAM_AW.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports wr_valid input 1, wr_addr input CAM_AW, wr_data input CAM_DW, wr_care input CAM_DW (1 = bit compared), wr_ready output 1: entry write.
REQ-006 SHALL have ports inv_valid input 1, inv_addr input CAM_AW, inv_ready output 1: single-entry invalidate.
REQ-007 SHALL have ports flush input 1: invalidate all entries.
REQ-008 SHALL have ports srch_valid input 1, srch_key input CAM_DW, srch_mask input CAM_DW (1 = bit compared), srch_ready output 1.
REQ-009 SHALL have ports res_valid output 1, res_ready input 1, res_hit output 1, res_addr output CAM_AW, res_data output CAM_DW, res_last output 1, match_cnt output CAM_AW+1.

Function
REQ-010 SHALL hold per entry: data (CAM_DW), care (CAM_DW), valid bit.
REQ-011 SHALL implement FSM IDLE -> MATCH -> DRAIN -> IDLE; MATCH always lasts exactly one cycle.
REQ-012 SHALL drive wr_ready = (state==IDLE); inv_ready = (state==IDLE) && !wr_valid; srch_ready = (state==IDLE) && !wr_valid && !inv_valid && !flush.
REQ-013 SHALL, on wr_valid && wr_ready, store wr_data/wr_care at wr_addr and set its valid bit; write to an already-valid address overwrites it.
REQ-014 SHALL, on inv_valid && inv_ready, clear valid bit of inv_addr; invalid address content irrelevant.
REQ-015 SHALL, on flush in IDLE, clear all valid bits that cycle; flush outside IDLE ignored; a same-cycle write in IDLE is applied after flush (written entry ends valid).
REQ-016 SHALL, on srch_valid && srch_ready, capture key/mask and enter MATCH.
REQ-017 SHALL in MATCH register hit vector: entry i hits iff valid[i] && ((data[i] ^ key) & care[i] & mask) == 0.
REQ-018 SHALL in MATCH register match_cnt = popcount(hit vector), range 0..2**CAM_AW.
REQ-019 SHALL assert res_valid in the cycle after MATCH (search accept at cycle N -> res_valid at N+2).
REQ-020 SHALL, with >=1 hit, present hits in ascending address order, one per res_valid && res_ready handshake, res_hit=1, res_data = stored data of res_addr.
REQ-021 SHALL clear the delivered bit from the hit vector on each handshake; res_last=1 on the final remaining hit.
REQ-022 SHALL, with zero hits, present one beat res_hit=0, res_addr=0, res_data=0, res_last=1, match_cnt=0.
REQ-023 SHALL hold res_* and match_cnt stable while res_valid && !res_ready.
REQ-024 SHALL return to IDLE in the cycle after the res_last handshake, deasserting res_valid; next search accepted at earliest that IDLE cycle.
REQ-025 SHALL block write/invalidate during MATCH/DRAIN (ready low), so results reflect table state at search accept.
REQ-026 SHALL keep match_cnt constant for the entire drain (not decremented).
REQ-027 SHALL, when all entries hit (match_cnt = 2**CAM_AW), use the full CAM_AW+1 width without wrap.

Reset
REQ-028 SHALL, with rst high at a clock edge, set state IDLE, clear all valid bits, res_valid=0, res_hit=0, res_last=0, res_addr=0, res_data=0, match_cnt=0.
REQ-029 SHALL abort any in-progress search on rst, discarding remaining hits; rst overrides all inputs that cycle.
REQ-030 SHALL not reset data/care storage; valid bits alone gate matching.

Verification
REQ-031 SHALL cover: write addr 2 data 0x0000_00A5 care 0xFFFF_FFFF, search key 0xA5 mask all-ones -> res_valid 2 cycles later, res_hit=1, res_addr=2, res_last=1, match_cnt=1.
REQ-032 SHALL cover: write 0x4000_0000 care 0xE000_0000 at addrs 1,5,9; search key 0x5FFF_FFFF mask 0xE000_0000, res_ready toggled -> addrs 1,5,9 in order, res_last only with 9, outputs stable while stalled, match_cnt=3.
REQ-033 SHALL cover: search with table empty or mask=0 with no valid entries -> single beat res_hit=0, res_last=1, match_cnt=0.
REQ-034 SHALL cover: fill all 16 entries, search mask=0 -> 16 hits addrs 0..15, match_cnt=16.
REQ-035 SHALL cover: invalidate addr 5 then repeat REQ-032 search -> addrs 1,9, match_cnt=2; flush then search -> miss.
REQ-036 SHALL cover: wr_valid and srch_valid same IDLE cycle -> write taken, srch_ready=0; rst asserted mid-drain -> res_valid=0 next cycle, all entries invalid.
